i2c_master_byte_sequencer: RTL

Byte-level controller for the I2C master. It transfers one 9-bit-slot byte (8 data bits MSB-first plus the acknowledge slot) by issuing go/finish handshakes to the single-bit read engine and the single-bit write engine. It never drives SCL or SDA itself. It sits between the transaction controller (command/response side) and the bit engines; START/STOP generation is out of scope.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_master_byte_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// i2c_pkg : shared types and constants for the I2C master byte sequencer
// Revision: 1.0
// ============================================================================
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      BIT  = 3'd1,
      GAP  = 3'd2,
      ACK  = 3'd3,
      RESP = 3'd4
   } state_t;

   localparam int BYTE_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/i2c_master_byte_sequencer.sv
`default_nettype none
// ============================================================================
// i2c_master_byte_sequencer : runs one 8-bit + ack slot via the bit engines
// Revision: 1.0
// ============================================================================
module i2c_master_byte_sequencer
   import i2c_pkg::*;
#(
   parameter bit ABORT_ON_ERROR = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_read,
   input  logic       cmd_ack,
   input  logic [7:0] wr_data,
   output logic       rsp_valid,
   output logic [7:0] rd_data,
   output logic       rsp_ack,
   output logic       rsp_error,
   output logic       rbit_go,
   input  logic       rbit_finish,
   input  logic       rbit_data,
   input  logic       rbit_error,
   output logic       wbit_go,
   output logic       wbit_data,
   input  logic       wbit_finish,
   input  logic       wbit_error
);

   state_t     state, state_nx;
   logic [7:0] shift, shift_nx;
   logic [3:0] count, count_nx;
   logic       err, err_nx;
   logic       is_read, is_read_nx;
   logic       ack_bit, ack_bit_nx;
   logic       cmd_ready_nx, rsp_valid_nx, rsp_ack_nx, rsp_error_nx;
   logic [7:0] rd_data_nx;
   logic       rbit_go_nx, wbit_go_nx, wbit_data_nx;

   // Data slots use the engine matching the direction; the ack slot uses the other one.
   logic use_rd, sel_finish, slot_err;
   always_comb begin
      use_rd     = (state == BIT) ? is_read : ~is_read;
      sel_finish = use_rd ? rbit_finish : wbit_finish;
      slot_err   = err | (use_rd ? rbit_error : wbit_error);
   end

   always_comb begin
      state_nx     = state;
      shift_nx     = shift;
      count_nx     = count;
      err_nx       = err;
      is_read_nx   = is_read;
      ack_bit_nx   = ack_bit;
      cmd_ready_nx = 1'b0;
      rsp_valid_nx = 1'b0;
      rd_data_nx   = rd_data;
      rsp_ack_nx   = rsp_ack;
      rsp_error_nx = rsp_error;
      rbit_go_nx   = rbit_go;
      wbit_go_nx   = wbit_go;
      wbit_data_nx = wbit_data;

      case (state)
         IDLE: begin
            cmd_ready_nx = 1'b1;
            if (cmd_valid) begin
               state_nx     = BIT;
               is_read_nx   = cmd_read;
               ack_bit_nx   = cmd_ack;
               // Reads start from zero so an aborted read reports only the bits received.
               shift_nx     = cmd_read ? 8'h00 : wr_data;
               count_nx     = 4'd0;
               err_nx       = 1'b0;
               rd_data_nx   = 8'h00;
               rsp_ack_nx   = 1'b0;
               rsp_error_nx = 1'b0;
               cmd_ready_nx = 1'b0;
               if (cmd_read) begin
                  rbit_go_nx = 1'b1;
               end else begin
                  wbit_go_nx   = 1'b1;
                  wbit_data_nx = wr_data[7];
               end
            end
         end
         BIT: begin
            if (sel_finish) begin
               rbit_go_nx = 1'b0;
               wbit_go_nx = 1'b0;
               shift_nx   = is_read ? {shift[6:0], rbit_data} : {shift[6:0], 1'b0};
               count_nx   = count + 4'd1;
               err_nx     = slot_err;
               if (slot_err && ABORT_ON_ERROR) begin
                  state_nx     = RESP;
                  rsp_valid_nx = 1'b1;
                  rd_data_nx   = is_read ? shift_nx : 8'h00;
                  rsp_ack_nx   = is_read ? ack_bit : 1'b0;
                  rsp_error_nx = 1'b1;
               end else begin
                  state_nx = GAP;
               end
            end
         end
         GAP: begin
            if (count == 4'(BYTE_BITS)) begin
               state_nx = ACK;
               if (is_read) begin
                  wbit_go_nx   = 1'b1;
                  wbit_data_nx = ack_bit;
               end else begin
                  rbit_go_nx = 1'b1;
               end
            end else begin
               state_nx = BIT;
               if (is_read) begin
                  rbit_go_nx = 1'b1;
               end else begin
                  wbit_go_nx   = 1'b1;
                  wbit_data_nx = shift[7];
               end
            end
         end
         ACK: begin
            if (sel_finish) begin
               rbit_go_nx   = 1'b0;
               wbit_go_nx   = 1'b0;
               err_nx       = slot_err;
               state_nx     = RESP;
               rsp_valid_nx = 1'b1;
               rd_data_nx   = is_read ? shift : 8'h00;
               rsp_ack_nx   = is_read ? ack_bit : rbit_data;
               rsp_error_nx = slot_err;
            end
         end
         RESP: begin
            state_nx     = IDLE;
            cmd_ready_nx = 1'b1;
         end
         default: begin
            state_nx     = IDLE;
            cmd_ready_nx = 1'b1;
            rbit_go_nx   = 1'b0;
            wbit_go_nx   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         shift     <= 8'h00;
         count     <= 4'd0;
         err       <= 1'b0;
         is_read   <= 1'b0;
         ack_bit   <= 1'b0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rd_data   <= 8'h00;
         rsp_ack   <= 1'b0;
         rsp_error <= 1'b0;
         rbit_go   <= 1'b0;
         wbit_go   <= 1'b0;
         wbit_data <= 1'b0;
      end else begin
         state     <= state_nx;
         shift     <= shift_nx;
         count     <= count_nx;
         err       <= err_nx;
         is_read   <= is_read_nx;
         ack_bit   <= ack_bit_nx;
         cmd_ready <= cmd_ready_nx;
         rsp_valid <= rsp_valid_nx;
         rd_data   <= rd_data_nx;
         rsp_ack   <= rsp_ack_nx;
         rsp_error <= rsp_error_nx;
         rbit_go   <= rbit_go_nx;
         wbit_go   <= wbit_go_nx;
         wbit_data <= wbit_data_nx;
      end
   end

endmodule
`default_nettype wire
